// File: rtl/reg_port_sched.sv
// Issue/writeback sequencer in front of an 8 x 16-bit two-read / one-write register file.
// Keeps a busy scoreboard of registers with outstanding writebacks and stalls issue on
// RAW/WAW hazards. The single write port goes round-robin to the writeback requesters.
module reg_port_sched #(
  parameter int unsigned NWB = 3,
  parameter int unsigned DW  = 16,
  parameter int unsigned AW  = 3
) (
  input  logic                clk,
  input  logic                rst,
  // issue side
  input  logic                iss_valid,
  input  logic [AW-1:0]       iss_rs1,
  input  logic [AW-1:0]       iss_rs2,
  input  logic [AW-1:0]       iss_rd,
  input  logic                iss_wr,
  output logic                iss_ready,
  // writeback requesters
  input  logic [NWB-1:0]      wb_valid,
  input  logic [NWB*AW-1:0]   wb_sel,
  input  logic [NWB*DW-1:0]   wb_data,
  output logic [NWB-1:0]      wb_ready,
  // register file ports
  output logic [AW-1:0]       RS1,
  output logic [AW-1:0]       RS2,
  output logic [AW-1:0]       WS,
  output logic                WE,
  output logic [DW-1:0]       IN,
  // status
  output logic [(1<<AW)-1:0]  busy,
  output logic                wb_err
);

  localparam int unsigned NR = 1 << AW;
  localparam int unsigned PW = (NWB > 2) ? 2 : 1;

  logic [NR-1:0] busy_q, busy_d;
  logic [PW-1:0] rr_ptr_q, rr_ptr_d;
  logic          wb_err_q, wb_err_d;

  logic          hz;
  logic          issue_set;
  logic [NWB-1:0] gnt;
  logic          gnt_any;
  logic [AW-1:0] gnt_sel;
  logic [DW-1:0] gnt_data;

  // Hazards look only at registered busy; a same-cycle clear is not forwarded.
  assign hz        = busy_q[iss_rs1] | busy_q[iss_rs2] | (iss_wr & busy_q[iss_rd]);
  assign iss_ready = iss_valid & ~hz;
  assign issue_set = iss_valid & iss_ready & iss_wr & (iss_rd != '0);

  // Round-robin arbiter: first pass from rr_ptr upward, second pass wraps to 0.
  // Grants are suppressed while rst is high so the write port is idle immediately.
  always_comb begin
    gnt      = '0;
    gnt_any  = 1'b0;
    gnt_sel  = '0;
    gnt_data = '0;
    rr_ptr_d = rr_ptr_q;
    for (int pass = 0; pass < 2; pass++) begin
      for (int k = 0; k < int'(NWB); k++) begin
        if (!rst && !gnt_any && wb_valid[k] && (pass == 1 || k >= int'(rr_ptr_q))) begin
          gnt[k]   = 1'b1;
          gnt_any  = 1'b1;
          gnt_sel  = wb_sel[k*AW +: AW];
          gnt_data = wb_data[k*DW +: DW];
          rr_ptr_d = (k == int'(NWB) - 1) ? '0 : PW'(k + 1);
        end
      end
    end
  end

  // Scoreboard next state: clear on writeback, then set on issue so a set wins.
  always_comb begin
    busy_d = busy_q;
    if (gnt_any) busy_d[gnt_sel] = 1'b0;
    if (issue_set) busy_d[iss_rd] = 1'b1;
    busy_d[0] = 1'b0;
    wb_err_d = wb_err_q | (gnt_any & ~busy_q[gnt_sel] & (gnt_sel != '0));
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q   <= '0;
      rr_ptr_q <= '0;
      wb_err_q <= 1'b0;
    end else begin
      busy_q   <= busy_d;
      rr_ptr_q <= rr_ptr_d;
      wb_err_q <= wb_err_d;
    end
  end

  assign RS1      = iss_rs1;
  assign RS2      = iss_rs2;
  assign WS       = gnt_sel;
  assign WE       = gnt_any;
  assign IN       = gnt_data;
  assign wb_ready = gnt;
  assign busy     = busy_q;
  assign wb_err   = wb_err_q;

endmodule

// File: tb/tb_reg_port_sched.sv
// Directed bench for reg_port_sched with a small register-file model on the write port.
module tb_reg_port_sched;

  logic        clk, rst;
  logic        iss_valid, iss_wr, iss_ready;
  logic [2:0]  iss_rs1, iss_rs2, iss_rd;
  logic [2:0]  wb_valid, wb_ready;
  logic [8:0]  wb_sel;
  logic [47:0] wb_data;
  logic [2:0]  RS1, RS2, WS;
  logic        WE;
  logic [15:0] IN;
  logic [7:0]  busy;
  logic        wb_err;

  int checks = 0;
  int errors = 0;

  reg_port_sched #(.NWB(3), .DW(16), .AW(3)) dut (
    .clk(clk), .rst(rst),
    .iss_valid(iss_valid), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_rd(iss_rd),
    .iss_wr(iss_wr), .iss_ready(iss_ready),
    .wb_valid(wb_valid), .wb_sel(wb_sel), .wb_data(wb_data), .wb_ready(wb_ready),
    .RS1(RS1), .RS2(RS2), .WS(WS), .WE(WE), .IN(IN),
    .busy(busy), .wb_err(wb_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Register file model: r0 discards writes and reads zero.
  logic [15:0] rf [8];
  logic [15:0] out1;
  always @(posedge clk) if (WE && WS != 3'd0) rf[WS] <= IN;
  always_comb out1 = (RS1 == 3'd0) ? 16'h0000 : rf[RS1];

  task automatic set_iss(input logic v, input logic [2:0] r1, input logic [2:0] r2,
                         input logic [2:0] rd, input logic wr);
    iss_valid = v; iss_rs1 = r1; iss_rs2 = r2; iss_rd = rd; iss_wr = wr;
  endtask

  task automatic set_wb(input int k, input logic v, input logic [2:0] sel,
                        input logic [15:0] data);
    wb_valid[k] = v;
    wb_sel[k*3 +: 3] = sel;
    wb_data[k*16 +: 16] = data;
  endtask

  task automatic idle_inputs();
    set_iss(1'b0, 3'd0, 3'd0, 3'd0, 1'b0);
    wb_valid = '0; wb_sel = '0; wb_data = '0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Issue rd=1,2,4 on consecutive cycles to build busy = 8'h16.
  task automatic fill_busy_124();
    @(negedge clk); set_iss(1'b1, 3'd0, 3'd0, 3'd1, 1'b1);
    @(negedge clk); set_iss(1'b1, 3'd0, 3'd0, 3'd2, 1'b1);
    @(negedge clk); set_iss(1'b1, 3'd0, 3'd0, 3'd4, 1'b1);
    @(negedge clk); set_iss(1'b0, 3'd0, 3'd0, 3'd0, 1'b0);
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy !== 8'h00) begin errors++; $display("FAIL reset_busy got %h exp 00", busy); end
    checks++; if (WE !== 1'b0) begin errors++; $display("FAIL reset_we got %b exp 0", WE); end
    checks++; if (wb_ready !== 3'b000) begin errors++; $display("FAIL reset_wb_ready got %b exp 000", wb_ready); end
    checks++; if (iss_ready !== 1'b0) begin errors++; $display("FAIL reset_iss_ready got %b exp 0", iss_ready); end
    checks++; if (wb_err !== 1'b0) begin errors++; $display("FAIL reset_wb_err got %b exp 0", wb_err); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_issue();
    @(negedge clk);
    set_iss(1'b1, 3'd1, 3'd2, 3'd3, 1'b1);
    #1;
    checks++; if (iss_ready !== 1'b1) begin errors++; $display("FAIL issue_ready got %b exp 1", iss_ready); end
    checks++; if (RS1 !== 3'd1 || RS2 !== 3'd2) begin errors++; $display("FAIL issue_rs got %0d/%0d exp 1/2", RS1, RS2); end
    @(posedge clk); #1;
    checks++; if (busy !== 8'h08) begin errors++; $display("FAIL issue_busy got %h exp 08", busy); end
  endtask

  task automatic test_raw_stall();
    @(negedge clk);
    set_iss(1'b1, 3'd3, 3'd1, 3'd0, 1'b0);
    set_wb(0, 1'b1, 3'd3, 16'h1234);
    #1;
    checks++; if (iss_ready !== 1'b0) begin errors++; $display("FAIL raw_stall got %b exp 0", iss_ready); end
    checks++; if (wb_ready !== 3'b001) begin errors++; $display("FAIL raw_grant got %b exp 001", wb_ready); end
    checks++; if (WE !== 1'b1 || WS !== 3'd3 || IN !== 16'h1234) begin
      errors++; $display("FAIL raw_wport got WE=%b WS=%0d IN=%h exp 1/3/1234", WE, WS, IN);
    end
    @(posedge clk); #1;
    checks++; if (busy !== 8'h00) begin errors++; $display("FAIL raw_clear got %h exp 00", busy); end
    @(negedge clk);
    set_wb(0, 1'b0, 3'd0, 16'h0000);
    #1;
    checks++; if (iss_ready !== 1'b1) begin errors++; $display("FAIL raw_release got %b exp 1", iss_ready); end
    checks++; if (out1 !== 16'h1234) begin errors++; $display("FAIL raw_out1 got %h exp 1234", out1); end
    checks++; if (wb_err !== 1'b0) begin errors++; $display("FAIL raw_no_err got %b exp 0", wb_err); end
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_g [3];
    logic [2:0] exp_ws [3];
    exp_g[0] = 3'b001; exp_g[1] = 3'b010; exp_g[2] = 3'b100;
    exp_ws[0] = 3'd1;  exp_ws[1] = 3'd2;  exp_ws[2] = 3'd4;
    pulse_reset();
    fill_busy_124();
    set_wb(0, 1'b1, 3'd1, 16'hAAAA);
    set_wb(1, 1'b1, 3'd2, 16'hBBBB);
    set_wb(2, 1'b1, 3'd4, 16'hCCCC);
    #1;
    checks++; if (busy !== 8'h16) begin errors++; $display("FAIL rr_setup got %h exp 16", busy); end
    for (int c = 0; c < 3; c++) begin
      if (c > 0) begin
        @(negedge clk);
        set_wb(c - 1, 1'b0, 3'd0, 16'h0000);
        #1;
      end
      checks++; if (wb_ready !== exp_g[c] || WS !== exp_ws[c]) begin
        errors++; $display("FAIL rr_grant%0d got %b/%0d exp %b/%0d", c, wb_ready, WS, exp_g[c], exp_ws[c]);
      end
      @(posedge clk);
    end
    @(negedge clk);
    set_wb(2, 1'b0, 3'd0, 16'h0000);
    #1;
    checks++; if (busy !== 8'h00) begin errors++; $display("FAIL rr_drain got %h exp 00", busy); end
    checks++; if (wb_err !== 1'b0) begin errors++; $display("FAIL rr_err got %b exp 0", wb_err); end
  endtask

  task automatic test_reset_mid();
    pulse_reset();
    fill_busy_124();
    set_iss(1'b1, 3'd1, 3'd0, 3'd0, 1'b0);
    set_wb(0, 1'b1, 3'd1, 16'h7777);
    #1;
    checks++; if (busy !== 8'h16 || iss_ready !== 1'b0) begin
      errors++; $display("FAIL mid_setup got busy=%h rdy=%b exp 16/0", busy, iss_ready);
    end
    checks++; if (wb_ready !== 3'b001) begin errors++; $display("FAIL mid_pre_grant got %b exp 001", wb_ready); end
    #2 rst = 1'b1;
    #1;
    checks++; if (busy !== 8'h00) begin errors++; $display("FAIL mid_busy got %h exp 00", busy); end
    checks++; if (wb_ready !== 3'b000 || WE !== 1'b0) begin
      errors++; $display("FAIL mid_wport got %b/%b exp 000/0", wb_ready, WE);
    end
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_no_starvation();
    logic [2:0] exp_g [4];
    exp_g[0] = 3'b010; exp_g[1] = 3'b100; exp_g[2] = 3'b010; exp_g[3] = 3'b100;
    @(negedge clk);
    set_wb(1, 1'b1, 3'd6, 16'h1111);
    for (int c = 0; c < 4; c++) begin
      if (c == 1) begin
        @(negedge clk);
        set_wb(2, 1'b1, 3'd7, 16'h2222);
      end else if (c > 1) begin
        @(negedge clk);
      end
      #1;
      checks++; if (wb_ready !== exp_g[c]) begin
        errors++; $display("FAIL starve_grant%0d got %b exp %b", c, wb_ready, exp_g[c]);
      end
      @(posedge clk);
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_wb_err();
    pulse_reset();
    #1;
    checks++; if (wb_err !== 1'b0) begin errors++; $display("FAIL err_cleared got %b exp 0", wb_err); end
    @(negedge clk);
    set_wb(0, 1'b1, 3'd0, 16'hFFFF);
    #1;
    checks++; if (WE !== 1'b1 || WS !== 3'd0) begin errors++; $display("FAIL err_r0_wport got %b/%0d exp 1/0", WE, WS); end
    @(posedge clk); #1;
    checks++; if (wb_err !== 1'b0) begin errors++; $display("FAIL err_r0 got %b exp 0", wb_err); end
    @(negedge clk);
    set_wb(0, 1'b1, 3'd5, 16'h5555);
    #1;
    checks++; if (WE !== 1'b1 || WS !== 3'd5) begin errors++; $display("FAIL err_r5_wport got %b/%0d exp 1/5", WE, WS); end
    @(posedge clk); #1;
    checks++; if (wb_err !== 1'b1) begin errors++; $display("FAIL err_set got %b exp 1", wb_err); end
    @(negedge clk);
    idle_inputs();
    set_iss(1'b1, 3'd0, 3'd0, 3'd0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    checks++; if (wb_err !== 1'b1) begin errors++; $display("FAIL err_sticky got %b exp 1", wb_err); end
    checks++; if (WE !== 1'b0 || WS !== 3'd0 || IN !== 16'h0000) begin
      errors++; $display("FAIL err_idle_wport got %b/%0d/%h exp 0/0/0000", WE, WS, IN);
    end
    checks++; if (out1 !== 16'h0000) begin errors++; $display("FAIL err_r0_read got %h exp 0000", out1); end
  endtask

  task automatic test_rd_zero();
    @(negedge clk);
    set_iss(1'b1, 3'd0, 3'd0, 3'd0, 1'b1);
    #1;
    checks++; if (iss_ready !== 1'b1) begin errors++; $display("FAIL rd0_ready got %b exp 1", iss_ready); end
    @(posedge clk); #1;
    checks++; if (busy !== 8'h00) begin errors++; $display("FAIL rd0_busy got %h exp 00", busy); end
    @(negedge clk);
    set_iss(1'b1, 3'd0, 3'd0, 3'd5, 1'b0);
    @(posedge clk); #1;
    checks++; if (busy !== 8'h00) begin errors++; $display("FAIL nowr_busy got %h exp 00", busy); end
    @(negedge clk);
    set_iss(1'b1, 3'd0, 3'd0, 3'd5, 1'b1);
    @(posedge clk); #1;
    checks++; if (busy !== 8'h20) begin errors++; $display("FAIL rd5_busy got %h exp 20", busy); end
    @(negedge clk);
    #1;
    checks++; if (iss_ready !== 1'b0) begin errors++; $display("FAIL waw_stall got %b exp 0", iss_ready); end
    set_iss(1'b1, 3'd0, 3'd0, 3'd5, 1'b0);
    #1;
    checks++; if (iss_ready !== 1'b1) begin errors++; $display("FAIL waw_nowr got %b exp 1", iss_ready); end
    @(negedge clk);
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_issue();
    test_raw_stall();
    test_round_robin();
    test_reset_mid();
    test_no_starvation();
    test_wb_err();
    test_rd_zero();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_port_sched.md
Name: reg_port_sched

Overview:
- Sequencing controller in front of reg_file: 8 x 16-bit registers, two read ports (RS1/RS2 -> OUT1/OUT2), one write port (WS/WE/IN) written on rising clk; r0 reads as zero.
- Keeps a busy scoreboard of registers with outstanding writebacks and stalls issue on RAW/WAW hazards.
- Arbitrates the single write port round-robin among NWB writeback requesters (ALU, load unit, multiplier).
- Drives RS1/RS2/WS/WE/IN of reg_file directly.

Parameters:
- NWB, 3, number of writeback requesters (2..4)
- DW, 16, register data width
- AW, 3, register select width (2**AW registers)

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- iss_valid  input  1  decode presents an instruction
- iss_rs1  input  AW  source 1 select
- iss_rs2  input  AW  source 2 select
- iss_rd  input  AW  destination select
- iss_wr  input  1  instruction will write iss_rd
- iss_ready  output  1  issue accepted this cycle (no hazard)
- wb_valid  input  NWB  writeback request per requester
- wb_sel  input  NWB*AW  destination per requester; requester k uses bits [k*AW +: AW]
- wb_data  input  NWB*DW  data per requester; requester k uses bits [k*DW +: DW]
- wb_ready  output  NWB  one-hot grant; write completes at this edge
- RS1  output  AW  to reg_file; equals iss_rs1
- RS2  output  AW  to reg_file; equals iss_rs2
- WS  output  AW  to reg_file; granted wb_sel
- WE  output  1  to reg_file; 1 when any grant
- IN  output  DW  to reg_file; granted wb_data
- busy  output  2**AW  scoreboard; bit 0 always 0
- wb_err  output  1  sticky: writeback to a non-busy register

Behaviour:
- Reset (async, immediate): busy=0, rr_ptr=0, wb_err=0. Outputs during and after reset: WE=0, wb_ready=0, iss_ready=0 whenever iss_valid=0.
- Read path is combinational pass-through: RS1=iss_rs1, RS2=iss_rs2. OUT1/OUT2 come from reg_file the same cycle.
- Hazard, evaluated on registered busy only (no same-cycle clear forwarding):
  - hz = busy[iss_rs1] | busy[iss_rs2] | (iss_wr & busy[iss_rd])
  - iss_ready = iss_valid & ~hz; combinational, no latency.
- Issue accept (iss_valid & iss_ready at the edge) with iss_wr=1 and iss_rd!=0: set busy[iss_rd] next cycle.
- rd=0 or iss_wr=0: no scoreboard change.
- Write arbitration, combinational, round-robin:
  - Search order starts at rr_ptr: rr_ptr, rr_ptr+1, ... mod NWB. First valid requester k is granted.
  - wb_ready[k]=1; WS=wb_sel[k]; IN=wb_data[k]; WE=1.
  - No valid request: WE=0, wb_ready=0, WS=0, IN=0.
- On a grant at the edge:
  - rr_ptr <= (k+1) mod NWB.
  - Clear busy[wb_sel[k]].
  - If busy[wb_sel[k]] was 0 and wb_sel[k]!=0, set wb_err (sticky until rst).
- No grant: rr_ptr holds.
- Writeback to r0: granted normally, WE=1; reg_file discards it; no wb_err.
- Simultaneous issue set and writeback clear on the same register in one cycle: set wins, busy stays 1. This is legal only after the prior writeback: issue for that rd sees busy=1 and stalls, so the case arises only when busy was already 0 and the clear is a wb_err case.
- Requester handshake:
  - Requester holds wb_valid, wb_sel and wb_data stable until wb_ready.
  - Non-granted requesters stall.
  - At most one grant per cycle.
- Reset mid-operation: scoreboard is lost; all pending writebacks are treated as spurious (they set wb_err if granted before a new issue sets busy).
- Implementation: busy is a 2**AW-bit register; bit 0 is forced to 0 at all times.

Test Plan:
- Reset, then iss_valid=1, rs1=1, rs2=2, rd=3, iss_wr=1 -> iss_ready=1; next cycle busy=8'b0000_1000.
- Busy[3]=1, issue rs1=3, rs2=1 -> iss_ready=0. Requester 0 writes sel=3, data=16'h1234 -> wb_ready=3'b001, WE=1, WS=3, IN=1234. Next cycle busy[3]=0, iss_ready=1, OUT1=1234.
- All three requesters valid, sels 1/2/4 all busy, for 3 cycles from reset -> grants 001, 010, 100 in order; WS=1, 2, 4; busy returns to 0.
- Requester 1 valid continuously, requester 2 raises valid -> next grant alternates 010, 100, 010 (no starvation).
- Writeback sel=5 with busy[5]=0 -> WE=1, wb_err=1 and stays 1. Writeback sel=0 -> wb_err unchanged, later OUT1 for RS1=0 reads 0000.
- Issue rd=0 with iss_wr=1 -> busy remains 0. Assert rst mid-stall with busy=8'b0001_0110 -> busy=0 and wb_ready=0 immediately, without a clock edge.
